int_to_float: RTL and testbench
===============================

INT_TO_FLOAT -- requirements
Module: int_to_float

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 input_a  input  32  two's-complement signed integer operand.
REQ-005 input_a_stb  input  1  producer asserts when input_a is valid.
REQ-006 input_a_ack  output  1  block ready to accept input_a.
REQ-007 output_z  output  32  IEEE-754 single-precision result.
REQ-008 output_z_stb  output  1  output_z valid.
REQ-009 output_z_ack  input  1  consumer accepts output_z.

Function
REQ-010 The block SHALL use states get_a, convert_0, normalise, round, pack, put_z, one operation in flight at a time.
REQ-011 get_a: input_a_ack SHALL be driven 1 on the first edge in this state; an operand SHALL be captured on the edge where input_a_ack=1 and input_a_stb=1, with input_a_ack cleared and the next state convert_0 on that same edge.
REQ-012 input_a_ack SHALL be 0 in every state other than get_a.
REQ-013 convert_0, operand 0: z SHALL be set to 0x00000000 (positive zero), next state put_z.
REQ-014 convert_0, nonzero: sign z_s = bit 31; magnitude = |a| as 32-bit unsigned (0x80000000 gives 2^31, no overflow); exponent z_e = 31; next state normalise.
REQ-015 normalise: while magnitude bit 31 = 0, shift magnitude left by 1 and decrement z_e, one shift per cycle; once bit 31 = 1, take one exit cycle to round.
REQ-016 On entry to round: z_m = magnitude[31:8], guard = bit 7, round_bit = bit 6, sticky = OR of bits 5:0.
REQ-017 round: round-to-nearest-even; if guard AND (round_bit OR sticky OR z_m[0]), increment z_m (24-bit wrap); if z_m was 0xFFFFFF before the increment, also increment z_e.
REQ-018 pack: z[31] = z_s, z[30:23] = z_e + 127, z[22:0] = z_m[22:0]; next state put_z. No overflow, NaN or denormal handling is required, since the exponent range is 0..31.
REQ-019 put_z: output_z_stb SHALL be driven 1 and output_z driven to z; on the edge where output_z_stb=1 and output_z_ack=1, output_z_stb SHALL clear and the next state SHALL be get_a.
REQ-020 output_z SHALL remain stable while output_z_stb=1 and output_z_ack=0, for unlimited backpressure.
REQ-021 Latency, input-handshake edge to output_z_stb rising: 2 edges for a zero operand; k+5 edges for a nonzero operand, where k = leading-zero count of the magnitude (0..31).
REQ-022 output_z_ack SHALL be ignored outside put_z, and input_a_stb SHALL be ignored outside get_a.
REQ-023 output_z_stb SHALL deassert for at least one cycle between results; the next input_a_ack SHALL rise no earlier than one edge after entering get_a.

Reset
REQ-024 When rst=1 at an edge: state SHALL become get_a; input_a_ack, output_z_stb and output_z SHALL become 0.
REQ-025 rst SHALL take priority over all state activity, including a handshake on the same edge.
REQ-026 A reset during any state SHALL abandon the in-flight operation with no output produced.
REQ-027 After rst is released, input_a_ack SHALL rise on the next edge.

Verification
REQ-028 Input 0x00000001 -> output 0x3F800000 with output_z_stb after 36 edges; input 0xFFFFFFFF -> output 0xBF800000.
REQ-029 Input 0x00000000 -> output 0x00000000 after 2 edges; input 0x80000000 -> output 0xCF000000 after 5 edges.
REQ-030 Rounding: 0x7FFFFFFF -> 0x4F000000 (mantissa carry-out); 0x01000001 -> 0x4B800000 (tie, even kept); 0x01000003 -> 0x4B800002 (tie, rounded up to even).
REQ-031 Backpressure: hold output_z_ack=0 for 20 cycles in put_z -> output_z and output_z_stb stay constant; ack=1 -> stb drops next edge and input_a_ack rises one edge later.
REQ-032 Reset during normalise (input 0x00000001, rst on cycle 10) -> no output_z_stb; next operand 0x00000003 -> 0x40400000.
REQ-033 Random signed operands, with stb/ack toggled randomly -> every result bit-exact against a reference round-to-nearest-even conversion, with no lost or duplicated transfers.

Source files
------------

// File: rtl/int_to_float.sv
// Converts a 32-bit two's-complement integer to IEEE-754 single precision.
// Uses a valid/ack handshake, with one operation in flight at a time.
module int_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        get_a,
        convert_0,
        normalise,
        round,
        pack,
        put_z
    } state_t;

    state_t      state, state_n;
    logic [31:0] a, a_n;
    logic [31:0] mag, mag_n;
    logic [31:0] z, z_n;
    logic [23:0] z_m, z_m_n;
    logic [7:0]  z_e, z_e_n;
    logic        z_s, z_s_n;
    logic        guard, guard_n;
    logic        round_bit, round_bit_n;
    logic        sticky, sticky_n;
    logic        input_a_ack_n;
    logic        output_z_stb_n;
    logic [31:0] output_z_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= get_a;
            input_a_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= '0;
        end else begin
            state        <= state_n;
            a            <= a_n;
            mag          <= mag_n;
            z            <= z_n;
            z_m          <= z_m_n;
            z_e          <= z_e_n;
            z_s          <= z_s_n;
            guard        <= guard_n;
            round_bit    <= round_bit_n;
            sticky       <= sticky_n;
            input_a_ack  <= input_a_ack_n;
            output_z_stb <= output_z_stb_n;
            output_z     <= output_z_n;
        end
    end

    always_comb begin
        state_n        = state;
        a_n            = a;
        mag_n          = mag;
        z_n            = z;
        z_m_n          = z_m;
        z_e_n          = z_e;
        z_s_n          = z_s;
        guard_n        = guard;
        round_bit_n    = round_bit;
        sticky_n       = sticky;
        input_a_ack_n  = 1'b0;
        output_z_stb_n = 1'b0;
        output_z_n     = output_z;

        case (state)
            get_a: begin
                input_a_ack_n = 1'b1;
                if (input_a_ack && input_a_stb) begin
                    a_n           = input_a;
                    input_a_ack_n = 1'b0;
                    state_n       = convert_0;
                end
            end
            convert_0: begin
                if (a == '0) begin
                    z_n     = '0;
                    state_n = put_z;
                end else begin
                    // Negating 0x80000000 yields 0x80000000, i.e. 2^31 unsigned
                    z_s_n   = a[31];
                    mag_n   = a[31] ? (~a + 32'd1) : a;
                    z_e_n   = 8'd31;
                    state_n = normalise;
                end
            end
            normalise: begin
                if (!mag[31]) begin
                    mag_n = mag << 1;
                    z_e_n = z_e - 8'd1;
                end else begin
                    z_m_n       = mag[31:8];
                    guard_n     = mag[7];
                    round_bit_n = mag[6];
                    sticky_n    = |mag[5:0];
                    state_n     = round;
                end
            end
            round: begin
                if (guard && (round_bit || sticky || z_m[0])) begin
                    z_m_n = z_m + 24'd1;
                    if (z_m == 24'hFFFFFF) begin
                        z_e_n = z_e + 8'd1;
                    end
                end
                state_n = pack;
            end
            pack: begin
                z_n     = {z_s, z_e + 8'd127, z_m[22:0]};
                state_n = put_z;
            end
            put_z: begin
                output_z_stb_n = 1'b1;
                output_z_n     = z;
                if (output_z_stb && output_z_ack) begin
                    output_z_stb_n = 1'b0;
                    state_n        = get_a;
                end
            end
            default: state_n = get_a;
        endcase
    end

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: directed vectors, latency,
// backpressure, mid-operation reset and randomized handshakes.
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_q[$];
    logic        rand_done;

    int_to_float dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference conversion: locate the MSB, truncate, then round to nearest even
    function automatic logic [31:0] ref_conv(input logic [31:0] val);
        logic        s;
        logic [63:0] mag, m, rem, half;
        int          e, sh;
        s   = val[31];
        mag = {32'd0, s ? (~val + 32'd1) : val};
        if (mag == 64'd0) return 32'd0;
        e = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) e = i;
        if (e <= 23) begin
            m = mag << (23 - e);
        end else begin
            sh   = e - 23;
            m    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 64'd1;
            if (m[24]) begin
                m = m >> 1;
                e = e + 1;
            end
        end
        return {s, 8'(e + 127), m[22:0]};
    endfunction

    // Results are compared on the negedge preceding the accepting posedge
    always @(negedge clk) begin
        if (!rst && output_z_stb && output_z_ack) begin
            if (exp_q.size() == 0) check("unexpected_output", 32'd1, 32'd0);
            else check("output_z", output_z, exp_q.pop_front());
        end
    end

    task automatic run_op(input logic [31:0] val, input logic [31:0] exp, input int lat);
        int i, n;
        input_a     = val;
        input_a_stb = 1'b1;
        i = 0;
        while (!input_a_ack && i < 20) begin
            @(posedge clk); #1;
            i++;
        end
        if (!input_a_ack) check("ack_timeout", 32'd0, 32'd1);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        input_a     = 32'hDEADBEEF;
        check("ack_low_after_capture", {31'd0, input_a_ack}, 32'd0);
        n = 0;
        while (!output_z_stb && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, lat);
    endtask

    task automatic release_z();
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
        check("stb_drop", {31'd0, output_z_stb}, 32'd0);
    endtask

    initial begin
        int seen, i;
        logic [31:0] v;
        rst          = 1'b1;
        input_a      = '0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;
        rand_done    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, input_a_ack}, 32'd0);
        check("rst_stb", {31'd0, output_z_stb}, 32'd0);
        check("rst_z", output_z, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ack_after_rst", {31'd0, input_a_ack}, 32'd1);

        run_op(32'h00000001, 32'h3F800000, 36); release_z();
        run_op(32'hFFFFFFFF, 32'hBF800000, 36); release_z();
        run_op(32'h00000000, 32'h00000000, 2);  release_z();
        run_op(32'h80000000, 32'hCF000000, 5);  release_z();
        run_op(32'h7FFFFFFF, 32'h4F000000, 6);  release_z();
        run_op(32'h01000001, 32'h4B800000, 12); release_z();
        run_op(32'h01000003, 32'h4B800002, 12); release_z();

        // Backpressure: result must hold across 20 stalled cycles
        run_op(32'h12345678, 32'h4D91A2B4, 8);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (!output_z_stb || output_z !== 32'h4D91A2B4) seen++;
        end
        check("hold_violations", seen, 0);
        check("hold_value", output_z, 32'h4D91A2B4);
        release_z();
        check("ack_still_low", {31'd0, input_a_ack}, 32'd0);
        @(posedge clk); #1;
        check("ack_after_put", {31'd0, input_a_ack}, 32'd1);

        // Reset in the middle of normalisation abandons the operation
        input_a     = 32'h00000001;
        input_a_stb = 1'b1;
        i = 0;
        while (!input_a_ack && i < 20) begin
            @(posedge clk); #1;
            i++;
        end
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_ack", {31'd0, input_a_ack}, 32'd0);
        seen = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (output_z_stb) seen++;
        end
        check("mid_rst_no_output", seen, 0);
        run_op(32'h00000003, 32'h40400000, 35); release_z();

        // Randomized phase: concurrent driver and random consumer ack
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    v = $urandom;
                    v = v >> $urandom_range(0, 31);
                    if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
                    if (k % 50 == 7) v = 32'h80000000;
                    if (k % 50 == 9) v = 32'h00000000;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    input_a     = v;
                    input_a_stb = 1'b1;
                    i = 0;
                    while (!input_a_ack && i < 500) begin
                        @(posedge clk); #1;
                        i++;
                    end
                    if (!input_a_ack) check("rand_ack_timeout", 32'd0, 32'd1);
                    exp_q.push_back(ref_conv(v));
                    @(posedge clk); #1;
                    input_a_stb = 1'b0;
                    input_a     = $urandom;
                end
                rand_done = 1'b1;
            end
            begin
                i = 0;
                while (!(rand_done && exp_q.size() == 0) && i < 60000) begin
                    @(posedge clk); #1;
                    output_z_ack = $urandom_range(0, 1) == 1;
                    i++;
                end
                output_z_ack = 1'b0;
            end
        join
        check("queue_drained", exp_q.size(), 0);
        check("no_stb_at_end", {31'd0, output_z_stb}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
